// File: rtl/if_stage_pkg.sv
// Shared types and constants for the ARVI instruction fetch stage.
//   IF_XLEN     : datapath/PC width used by the fetch entry record
//   IF_NOP_INST : addi x0,x0,0, shown on an empty slot or on a fault entry
//   if_state_t  : fetch sequencer states
//   if_entry_t  : one IF/ID record {inst, pc, fault, misaligned}
package if_stage_pkg;

  localparam int unsigned IF_XLEN     = 32;
  localparam logic [31:0] IF_NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN,
    DISCARD,
    HALT
  } if_state_t;

  typedef struct packed {
    logic [31:0]        inst;
    logic [IF_XLEN-1:0] pc;
    logic               fault;
    logic               misaligned;
  } if_entry_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding register for a fetched IF/ID record.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clr        : drop the held entry (flush)
//   i_push       : capture i_entry (wins over i_pop in the same cycle)
//   i_pop        : release the held entry
//   o_valid      : an entry is held
//   o_entry      : the held entry
module if_skid_buf
  import if_stage_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_clr,
  input  logic      i_push,
  input  logic      i_pop,
  input  if_entry_t i_entry,
  output logic      o_valid,
  output if_entry_t o_entry
);

  logic      valid_q, valid_d;
  if_entry_t entry_q, entry_d;

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (i_clr) begin
      valid_d = 1'b0;
    end else if (i_push) begin
      valid_d = 1'b1;
      entry_d = i_entry;
    end else if (i_pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign o_valid = valid_q;
  assign o_entry = entry_q;

endmodule

// File: rtl/if_stage.sv
// ARVI instruction fetch stage: owns the fetch PC, issues req/ack bus
// fetches and fills the IF/ID output slot consumed by decode.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_stall                 : decode not accepting, slot holds
//   i_redirect/_pc          : branch/jump/trap flush and new fetch address
//   o_ibus_req/_addr        : instruction bus request and address
//   i_ibus_ack/_rdata/_err  : one-cycle response strobe with data/fault
//   o_valid, o_inst, o_pc   : IF/ID slot contents
//   o_ex_inst_fault         : slot entry is an instruction access fault
//   o_ex_inst_misaligned    : slot entry is a misaligned-target fault
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned     XLEN     = IF_XLEN,
  parameter logic [XLEN-1:0] PC_RESET = 32'h8000_0000,
  parameter logic [31:0]     NOP_INST = IF_NOP_INST
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stall,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_ibus_req,
  output logic [XLEN-1:0] o_ibus_addr,
  input  logic            i_ibus_ack,
  input  logic [31:0]     i_ibus_rdata,
  input  logic            i_ibus_err,
  output logic            o_valid,
  output logic [31:0]     o_inst,
  output logic [XLEN-1:0] o_pc,
  output logic            o_ex_inst_fault,
  output logic            o_ex_inst_misaligned
);

  if_state_t       state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] discard_pc_q, discard_pc_d;
  logic            valid_q, valid_d;
  if_entry_t       slot_q, slot_d;

  logic            skid_valid, skid_push, skid_pop, skid_clr;
  if_entry_t       skid_entry, ack_entry, fault_entry;
  logic            can_load, ack_ok;

  if_skid_buf u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (skid_clr),
    .i_push  (skid_push),
    .i_pop   (skid_pop),
    .i_entry (ack_entry),
    .o_valid (skid_valid),
    .o_entry (skid_entry)
  );

  // Bus request: RUN stops asking once the skid is occupied, so at most one
  // response can ever be waiting behind a stalled slot.
  always_comb begin
    o_ibus_req  = 1'b0;
    o_ibus_addr = fetch_pc_q;
    if (!i_rst) begin
      case (state_q)
        RUN:     o_ibus_req = !skid_valid;
        DISCARD: begin
          o_ibus_req  = 1'b1;
          o_ibus_addr = discard_pc_q;
        end
        default: o_ibus_req = 1'b0;
      endcase
    end
  end

  assign can_load = !valid_q || !i_stall;
  assign ack_ok   = i_ibus_ack && o_ibus_req;

  always_comb begin
    ack_entry = '{inst: (i_ibus_err ? NOP_INST : i_ibus_rdata), pc: fetch_pc_q,
                  fault: i_ibus_err, misaligned: 1'b0};
    // A misaligned target is only ever parked in fetch_pc while a discard
    // drains, so its fault record is built from fetch_pc in that case.
    fault_entry = '{inst: NOP_INST, pc: (i_redirect ? i_redirect_pc : fetch_pc_q),
                    fault: 1'b0, misaligned: 1'b1};

    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    discard_pc_d = discard_pc_q;
    valid_d      = valid_q;
    slot_d       = slot_q;
    skid_push    = 1'b0;
    skid_pop     = 1'b0;
    skid_clr     = 1'b0;

    if (i_redirect) begin
      skid_clr   = 1'b1;
      fetch_pc_d = i_redirect_pc;
      valid_d    = 1'b0;
      slot_d     = '{inst: NOP_INST, pc: slot_q.pc, fault: 1'b0, misaligned: 1'b0};
      if (state_q == DISCARD && !ack_ok) begin
        state_d = DISCARD;
      end else if (state_q != DISCARD && o_ibus_req && !ack_ok) begin
        state_d      = DISCARD;
        discard_pc_d = o_ibus_addr;
      end else if (i_redirect_pc[1:0] != 2'b00) begin
        state_d = HALT;
        valid_d = 1'b1;
        slot_d  = fault_entry;
      end else begin
        state_d = RUN;
      end
    end else begin
      if (can_load) begin
        valid_d = 1'b0;
        slot_d  = '{inst: NOP_INST, pc: slot_q.pc, fault: 1'b0, misaligned: 1'b0};
        if (skid_valid) begin
          valid_d  = 1'b1;
          slot_d   = skid_entry;
          skid_pop = 1'b1;
        end
      end
      case (state_q)
        RUN: begin
          if (ack_ok) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (i_ibus_err) state_d = HALT;
            if (can_load && !skid_valid) begin
              valid_d = 1'b1;
              slot_d  = ack_entry;
            end else begin
              skid_push = 1'b1;
            end
          end
        end
        DISCARD: begin
          if (ack_ok) begin
            if (fetch_pc_q[1:0] != 2'b00) begin
              state_d = HALT;
              valid_d = 1'b1;
              slot_d  = fault_entry;
            end else begin
              state_d = RUN;
            end
          end
        end
        default: state_d = HALT;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= RUN;
      fetch_pc_q   <= PC_RESET;
      discard_pc_q <= PC_RESET;
      valid_q      <= 1'b0;
      slot_q       <= '{inst: NOP_INST, pc: PC_RESET, fault: 1'b0, misaligned: 1'b0};
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      discard_pc_q <= discard_pc_d;
      valid_q      <= valid_d;
      slot_q       <= slot_d;
    end
  end

  assign o_valid              = valid_q;
  assign o_inst               = slot_q.inst;
  assign o_pc                 = slot_q.pc;
  assign o_ex_inst_fault      = slot_q.fault;
  assign o_ex_inst_misaligned = slot_q.misaligned;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a memory model answers requests with
// rdata=addr; expected IF/ID entries are queued when a response is given
// and compared when the entry appears in the slot.
module tb_if_stage;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] ERR_ADDR = 32'h8000_0020;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc;
  logic        ibus_req, ibus_ack, ibus_err;
  logic [31:0] ibus_addr, ibus_rdata;
  logic        o_valid, o_fault, o_mis;
  logic [31:0] o_inst, o_pc;

  logic        auto_mode;
  logic        man_ack, man_err;
  logic [31:0] man_rdata;

  exp_t        q[$];
  logic [31:0] exp_fetch;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign ibus_ack   = auto_mode ? ibus_req : man_ack;
  assign ibus_rdata = auto_mode ? ibus_addr : man_rdata;
  assign ibus_err   = auto_mode ? (ibus_addr == ERR_ADDR) : man_err;

  if_stage #(
    .XLEN     (32),
    .PC_RESET (32'h8000_0000),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_stall              (stall),
    .i_redirect           (redirect),
    .i_redirect_pc        (redirect_pc),
    .o_ibus_req           (ibus_req),
    .o_ibus_addr          (ibus_addr),
    .i_ibus_ack           (ibus_ack),
    .i_ibus_rdata         (ibus_rdata),
    .i_ibus_err           (ibus_err),
    .o_valid              (o_valid),
    .o_inst               (o_inst),
    .o_pc                 (o_pc),
    .o_ex_inst_fault      (o_fault),
    .o_ex_inst_misaligned (o_mis)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: inputs are already set by the caller at a negedge.
  task automatic cycle();
    exp_t e;
    logic load_ok;
    #1;
    if (auto_mode && !rst && ibus_req) check("req_addr", ibus_addr, exp_fetch);
    if (auto_mode && !rst && ibus_req && ibus_ack && !redirect) begin
      e.fault = (exp_fetch == ERR_ADDR);
      e.inst  = e.fault ? NOP : exp_fetch;
      e.pc    = exp_fetch;
      e.mis   = 1'b0;
      q.push_back(e);
      exp_fetch = exp_fetch + 32'd4;
    end
    if (redirect && !rst) begin
      q.delete();
      exp_fetch = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        e.inst = NOP; e.pc = redirect_pc; e.fault = 1'b0; e.mis = 1'b1;
        q.push_back(e);
      end
    end
    load_ok = !o_valid || !stall || redirect || rst;
    @(posedge clk);
    @(negedge clk);
    if (!rst && o_valid && load_ok) begin
      if (q.size() == 0) begin
        check("spurious_entry", o_valid, 1'b0);
      end else begin
        e = q.pop_front();
        check("inst", o_inst, e.inst);
        check("pc", o_pc, e.pc);
        check("fault", o_fault, e.fault);
        check("misaligned", o_mis, e.mis);
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    auto_mode = 1'b1; man_ack = 1'b0; man_err = 1'b0; man_rdata = '0;
    exp_fetch = 32'h8000_0000;

    // reset
    check("rst_req", ibus_req, 1'b0);
    cycle();
    cycle();
    check("rst_valid", o_valid, 1'b0);
    check("rst_inst", o_inst, NOP);
    check("rst_pc", o_pc, 32'h8000_0000);
    check("rst_fault", o_fault, 1'b0);
    check("rst_mis", o_mis, 1'b0);
    check("rst_req_hi", ibus_req, 1'b0);
    rst = 1'b0;

    // streaming, one ack per cycle
    #1;
    check("first_req", ibus_req, 1'b1);
    check("first_addr", ibus_addr, 32'h8000_0000);
    for (int unsigned i = 0; i < 3; i++) begin
      cycle();
      check("stream_valid", o_valid, 1'b1);
    end

    // stall: one response lands in the skid, requests stop
    stall = 1'b1;
    cycle();
    for (int unsigned i = 0; i < 2; i++) begin
      check("stall_req", ibus_req, 1'b0);
      check("stall_hold_pc", o_pc, 32'h8000_0008);
      cycle();
    end
    stall = 1'b0;
    check("skid_req", ibus_req, 1'b0);
    cycle();
    check("skid_out_pc", o_pc, 32'h8000_000C);

    // redirect with an outstanding request, late ack discarded
    auto_mode = 1'b0;
    check("resume_req", ibus_req, 1'b1);
    check("resume_addr", ibus_addr, 32'h8000_0010);
    cycle();
    check("gap_valid", o_valid, 1'b0);
    redirect = 1'b1; redirect_pc = 32'h8000_0100;
    cycle();
    redirect = 1'b0;
    check("disc_req", ibus_req, 1'b1);
    check("disc_addr", ibus_addr, 32'h8000_0010);
    check("disc_valid", o_valid, 1'b0);
    cycle();
    man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
    check("disc_addr2", ibus_addr, 32'h8000_0010);
    cycle();
    man_ack = 1'b0;
    check("disc_drop_valid", o_valid, 1'b0);
    check("post_disc_req", ibus_req, 1'b1);
    check("post_disc_addr", ibus_addr, 32'h8000_0100);
    auto_mode = 1'b1;
    cycle();
    cycle();

    // redirect coinciding with an ack
    redirect = 1'b1; redirect_pc = 32'h8000_0018;
    cycle();
    redirect = 1'b0;
    check("redir_ack_valid", o_valid, 1'b0);
    check("redir_ack_addr", ibus_addr, 32'h8000_0018);

    // bus error at 0x8000_0020 halts fetch
    for (int unsigned i = 0; i < 3; i++) cycle();
    check("err_valid", o_valid, 1'b1);
    check("err_fault", o_fault, 1'b1);
    check("err_req", ibus_req, 1'b0);
    for (int unsigned i = 0; i < 2; i++) begin
      cycle();
      check("halt_req", ibus_req, 1'b0);
      check("halt_valid", o_valid, 1'b0);
    end
    redirect = 1'b1; redirect_pc = 32'h8000_0200;
    cycle();
    redirect = 1'b0;
    check("restart_addr", ibus_addr, 32'h8000_0200);
    cycle();
    cycle();

    // misaligned redirect, held under stall
    redirect = 1'b1; redirect_pc = 32'h8000_0102;
    cycle();
    redirect = 1'b0;
    check("mis_valid", o_valid, 1'b1);
    check("mis_flag", o_mis, 1'b1);
    check("mis_req", ibus_req, 1'b0);
    stall = 1'b1;
    for (int unsigned i = 0; i < 2; i++) begin
      cycle();
      check("mis_hold_valid", o_valid, 1'b1);
      check("mis_hold_pc", o_pc, 32'h8000_0102);
      check("mis_hold_req", ibus_req, 1'b0);
    end
    redirect = 1'b1; redirect_pc = 32'h8000_0300;
    cycle();
    redirect = 1'b0; stall = 1'b0;
    check("mis_exit_valid", o_valid, 1'b0);
    check("mis_exit_req", ibus_req, 1'b1);
    check("mis_exit_addr", ibus_addr, 32'h8000_0300);
    cycle();

    // misaligned redirect while a request is outstanding
    auto_mode = 1'b0;
    check("out_addr", ibus_addr, 32'h8000_0304);
    cycle();
    redirect = 1'b1; redirect_pc = 32'h8000_0401;
    cycle();
    redirect = 1'b0;
    check("mis_disc_req", ibus_req, 1'b1);
    check("mis_disc_addr", ibus_addr, 32'h8000_0304);
    check("mis_disc_valid", o_valid, 1'b0);
    man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
    cycle();
    man_ack = 1'b0;
    check("mis_disc_flag", o_mis, 1'b1);
    check("mis_disc_req2", ibus_req, 1'b0);

    // PC wrap-around at the top of the address space
    auto_mode = 1'b1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    cycle();
    redirect = 1'b0;
    for (int unsigned i = 0; i < 4; i++) cycle();
    auto_mode = 1'b0;
    cycle();
    check("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction fetch stage of the ARVI pipeline: the producer end of the IF/ID interface that the decode stage consumes (inst, pc).
- Owns the fetch PC and issues requests on the instruction bus via a req/ack handshake.
- Registers each fetched word with its PC into the IF/ID output slot; a 1-entry skid buffer absorbs the one response that can land while decode stalls.
- Handles redirects (branch/jump/trap), discarding in-flight responses, and instruction access/misalignment faults.

Parameters:
- XLEN, 32, datapath/PC width.
- PC_RESET, 32'h8000_0000, fetch address after reset.
- NOP_INST, 32'h0000_0013, instruction presented when o_valid=0 or on a fault entry (addi x0,x0,0).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_stall  in  1  decode not accepting; IF/ID output slot holds its value.
- i_redirect  in  1  taken branch/jump/trap; flushes the stage.
- i_redirect_pc  in  XLEN  new fetch address, sampled when i_redirect=1.
- o_ibus_req  out  1  instruction bus request.
- o_ibus_addr  out  XLEN  request address; stable while o_ibus_req=1 and no ack.
- i_ibus_ack  in  1  one-cycle response strobe; rdata/err valid in the same cycle.
- i_ibus_rdata  in  32  fetched instruction.
- i_ibus_err  in  1  access fault for this response.
- o_valid  out  1  IF/ID slot holds a real entry.
- o_inst  out  32  instruction to decode.
- o_pc  out  XLEN  PC of o_inst.
- o_ex_inst_fault  out  1  entry is an instruction access fault.
- o_ex_inst_misaligned  out  1  entry is a misaligned-target fault.

Behaviour:
- Reset (i_rst=1 at clock edge): state RUN, fetch_pc=PC_RESET, o_valid=0, o_inst=NOP_INST, o_pc=PC_RESET, both fault outputs 0, skid empty. o_ibus_req=0 while i_rst is high; req=1 at PC_RESET in the first cycle after reset. Reset overrides any outstanding request (bus owner must tolerate abandonment).
- States: RUN, DISCARD, HALT.
- o_ibus_req is combinational:
  - RUN: req = !skid_valid.
  - DISCARD: req = 1.
  - HALT: req = 0.
- o_ibus_addr: fetch_pc in RUN, discard_pc in DISCARD. It changes only on ack or redirect. Once req is high it never drops before ack, except on redirect.
- Slot advance: the slot may be loaded when !o_valid || !i_stall. If it may be loaded and nothing new arrives, o_valid goes to 0 and o_inst to NOP_INST. If i_stall=1 and o_valid=1, all outputs hold.
- Source priority into the slot, when it may be loaded: skid entry first, then the current ack.
- Ack in RUN, no redirect:
  - Entry is {rdata, fetch_pc, err}; fetch_pc <= fetch_pc+4.
  - If the slot may be loaded and skid is empty, the entry goes to the slot; otherwise it goes to skid.
  - Latency: ack at cycle N → o_valid=1 at N+1.
  - Throughput: 1 instruction/cycle with same-cycle ack.
- Bus error: the entry carries o_ex_inst_fault=1 with o_inst=NOP_INST. State goes to HALT (no further requests until a redirect).
- Redirect (highest priority after reset; overrides i_stall):
  - o_valid <= 0, skid cleared, fetch_pc <= i_redirect_pc.
  - If req was high with no ack this cycle: discard_pc <= old address, state → DISCARD.
  - If ack arrives in the redirect cycle, that data is dropped.
- DISCARD: keeps req at discard_pc until ack. The ack (data and err) is dropped, state → RUN, and the request at fetch_pc starts the next cycle. A further redirect in DISCARD only updates fetch_pc.
- Misaligned redirect (i_redirect_pc[1:0]!=0):
  - No request is made.
  - Next cycle: slot holds {NOP_INST, i_redirect_pc, misaligned=1}, o_valid=1, state HALT.
  - If a request was outstanding, DISCARD completes first, then the fault entry is emitted and the state goes to HALT.
- HALT: leaves only on redirect. The fault entry is held under stall like any entry.
- PC arithmetic: modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0 with no fault.

Decomposition:
- arvi_defines.svh / shared package: NOP_INST constant, if_state_t enum {RUN, DISCARD, HALT}, if_entry_t struct {inst, pc, fault, misaligned}.
- One sub-module: if_skid_buf, a 1-entry if_entry_t holding register with push/pop/valid.

Test Plan:
- Reset, memory acking every cycle with rdata=addr → req at 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles; o_inst/o_pc match one cycle after each ack, o_valid continuous.
- Hold i_stall=1 for 3 cycles mid-stream → exactly one ack lands in skid and req drops. On release, the skid entry appears next cycle, then fetch resumes at the next sequential PC; no loss or duplication.
- Req outstanding at 0x8000_0010, redirect to 0x8000_0100, ack 2 cycles later with rdata=0xDEAD_BEEF → data never visible; next req at 0x8000_0100; o_valid=0 in between.
- Redirect and ack in the same cycle → acked data dropped; next req at the redirect PC.
- Ack with i_ibus_err=1 at 0x8000_0020 → o_valid=1, o_ex_inst_fault=1, o_inst=0x0000_0013, o_pc=0x8000_0020; req stays 0 until redirect to 0x8000_0200, which resumes fetch.
- Redirect to 0x8000_0102 → no request issued; entry with misaligned=1, o_pc=0x8000_0102; stage halted. A later redirect to 0x8000_0300 restarts fetch.
